bpu_update_ctrl: RTL and testbench
==================================

Name: bpu_update_ctrl

Overview:
- Sequences all writes into the branch history table and branch target buffer (BHT/BTB) through one shared update port.
- Owns three jobs:
  - the multi-cycle reset/flush sweep that clears every entry, one per cycle;
  - a small FIFO that absorbs EX-stage branch resolutions while a sweep runs;
  - mispredict detection, which produces a registered fetch redirect.
- Sits between EX and the BHT/BTB write ports; fetch-side reads are untouched.

Parameters:
- ENTRIES, 64, number of BHT/BTB entries (power of 2).
- IDX_W, 6, log2(ENTRIES); the table index is pc[IDX_W+1:2].
- QDEPTH, 4, update FIFO depth (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_ex_valid  in  1  resolved instruction present in EX this cycle.
- i_ex_is_branch  in  1  EX instruction is a conditional branch.
- i_ex_pc  in  32  PC of the EX instruction.
- i_ex_taken  in  1  actual branch outcome.
- i_ex_target  in  32  computed taken target.
- i_ex_pred_taken  in  1  direction predicted at fetch.
- i_ex_pred_target  in  32  target used at fetch.
- i_flush_req  in  1  one-cycle pulse requesting predictor invalidation.
- o_ex_stall  out  1  FIFO cannot accept; EX must hold.
- o_upd_valid  out  1  apply a training update this cycle.
- o_upd_pc  out  32  PC for the update (index and tag are derived by the tables).
- o_upd_taken  out  1  outcome for the 2-bit counter and BTB allocate.
- o_upd_target  out  32  target for BTB allocate.
- o_sweep_valid  out  1  write the default value at o_sweep_index (BHT=01, BTB valid=0).
- o_sweep_index  out  IDX_W  entry being cleared.
- o_ready  out  1  high in RUN only.
- o_redirect_valid  out  1  mispredict redirect pulse.
- o_redirect_pc  out  32  correct next PC.
- o_mispredict_cnt  out  32  wrapping count of mispredicts.

Behaviour:
- State machine:
  - States: INIT, RUN, FLUSH.
  - Reset enters INIT with the sweep counter at 0.
  - INIT/FLUSH drive o_sweep_valid=1 and o_sweep_index=counter each cycle.
  - After index ENTRIES-1 is written, the next state is RUN. A sweep therefore lasts exactly ENTRIES cycles.
  - In RUN, i_flush_req moves to FLUSH on the next cycle with the counter at 0.
  - i_flush_req is ignored in INIT and FLUSH.
- Reset values:
  - o_upd_valid, o_redirect_valid, o_ready, o_mispredict_cnt = 0; o_redirect_pc = 0.
  - o_sweep_valid = 1 and o_sweep_index = 0 in the first cycle after reset.
  - FIFO empty.
- FIFO:
  - An entry is pushed when i_ex_valid & i_ex_is_branch & !o_ex_stall. Non-branches are never queued.
  - o_ex_stall = (count == QDEPTH), combinational from registered count.
  - Pop only in RUN, one per cycle. o_upd_* is driven directly from the FIFO head, so o_upd_valid = RUN & !empty.
  - Minimum latency is 1 cycle: push in cycle N, update visible in N+1.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo QDEPTH.
  - o_upd_valid and o_sweep_valid are never high together (mutually exclusive by state).
- Flush:
  - On entering FLUSH, the FIFO is emptied (stale training is discarded).
  - Pushes during FLUSH are kept and drained after return to RUN.
  - A push in the same cycle as the flush request is discarded with the rest of the FIFO.
- Mispredict detection:
  - Evaluated on accepted pushes only.
  - mispredict = (taken != pred_taken) | (taken & pred_taken & target != pred_target).
  - Registered: o_redirect_valid pulses one cycle after the push.
  - o_redirect_pc = taken ? target : pc+4, with 32-bit wraparound.
  - o_mispredict_cnt increments in the same cycle the redirect is registered, wrapping at 2^32.
  - Detection operates in every state, including during a sweep.
- Reset mid-operation: the FIFO is cleared, the counter goes to 0, the state returns to INIT, and any pending redirect is dropped.

Decomposition:
- Shared package bpu_pkg:
  - state enum {INIT, RUN, FLUSH};
  - BHT_DEFAULT=2'b01;
  - update record {pc, taken, target} (65 bits);
  - index-extraction function pc[IDX_W+1:2].
- One sub-module, bpu_upd_fifo: parameterised sync FIFO with push/pop/flush, full/empty, count.

Test Plan:
- Reset, idle: o_sweep_index steps 0..63 over 64 cycles, then o_ready=1 in cycle 65 and o_sweep_valid=0.
- In RUN, push branch pc=0x100, taken=1, target=0x140, pred_taken=0: o_upd_valid next cycle with pc=0x100, and the same cycle o_redirect_valid=1, o_redirect_pc=0x140, cnt=1.
- Push pc=0x200, taken=0, pred_taken=1: redirect to 0x204.
- Push taken=1, pred_taken=1, target 0x300 vs pred 0x304: redirect to 0x300.
- Correct prediction: no redirect, update still issued.
- During INIT, push 5 consecutive branches: o_ex_stall=1 on the 5th attempt (count=4). After INIT, four updates drain in order on consecutive cycles, then the held branch is accepted.
- In RUN with 2 queued entries, pulse i_flush_req: FIFO emptied, 64-cycle sweep, no o_upd_valid during sweep. A branch pushed mid-sweep updates in the first RUN cycle.
- Assert rst at sweep index 30 during FLUSH: next cycle INIT at index 0, cnt=0, FIFO empty, o_redirect_valid=0.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared types and constants for the branch predictor update path.
package bpu_pkg;

  localparam logic [1:0] BHT_DEFAULT = 2'b01;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    FLUSH
  } bpu_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } upd_rec_t;

  // Word-aligned PCs: the low two bits never select an entry.
  function automatic logic [31:0] bpu_idx(input logic [31:0] pc, input int idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

endpackage

// File: rtl/bpu_upd_fifo.sv
// Small synchronous FIFO for queued predictor training records.
module bpu_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Flush drops everything, including a push arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/bpu_update_ctrl.sv
// Arbitrates BHT/BTB writes between the clearing sweep and EX training updates,
// and raises a registered fetch redirect on mispredicted branches.
module bpu_update_ctrl
  import bpu_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6,
  parameter int QDEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ex_valid,
  input  logic             i_ex_is_branch,
  input  logic [31:0]      i_ex_pc,
  input  logic             i_ex_taken,
  input  logic [31:0]      i_ex_target,
  input  logic             i_ex_pred_taken,
  input  logic [31:0]      i_ex_pred_target,
  input  logic             i_flush_req,
  output logic             o_ex_stall,
  output logic             o_upd_valid,
  output logic [31:0]      o_upd_pc,
  output logic             o_upd_taken,
  output logic [31:0]      o_upd_target,
  output logic             o_sweep_valid,
  output logic [IDX_W-1:0] o_sweep_index,
  output logic             o_ready,
  output logic             o_redirect_valid,
  output logic [31:0]      o_redirect_pc,
  output logic [31:0]      o_mispredict_cnt
);

  localparam int CW = $clog2(QDEPTH) + 1;

  bpu_state_e       state_q;
  bpu_state_e       state_d;
  logic [IDX_W-1:0] sweep_cnt;

  upd_rec_t         push_rec;
  upd_rec_t         head_rec;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;
  logic             mispredict;
  logic [31:0]      correct_pc;

  // The sweep counter only advances while clearing; it rests at 0 in RUN
  // so that a flush always starts from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      sweep_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != RUN) begin
        sweep_cnt <= sweep_cnt + IDX_W'(1);
      end else begin
        sweep_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT, FLUSH: begin
        if (sweep_cnt == IDX_W'(ENTRIES - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (i_flush_req) begin
          state_d = FLUSH;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    o_sweep_valid = (state_q != RUN);
    o_sweep_index = sweep_cnt;
    o_ready       = (state_q == RUN);
    o_upd_valid   = (state_q == RUN) && !fifo_empty;
    o_upd_pc      = head_rec.pc;
    o_upd_taken   = head_rec.taken;
    o_upd_target  = head_rec.target;
  end

  assign o_ex_stall = (fifo_count == CW'(QDEPTH));
  assign fifo_push  = i_ex_valid && i_ex_is_branch && !fifo_full;
  assign fifo_pop   = (state_q == RUN) && !fifo_empty;
  assign fifo_flush = (state_q == RUN) && i_flush_req;

  assign push_rec.pc     = i_ex_pc;
  assign push_rec.taken  = i_ex_taken;
  assign push_rec.target = i_ex_target;

  bpu_upd_fifo #(
    .DEPTH(QDEPTH),
    .WIDTH($bits(upd_rec_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_rec),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head_data (head_rec),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign mispredict = (i_ex_taken != i_ex_pred_taken) ||
                      (i_ex_taken && i_ex_pred_taken && (i_ex_target != i_ex_pred_target));
  assign correct_pc = i_ex_taken ? i_ex_target : (i_ex_pc + 32'd4);

  // Detection runs in every state so that a branch resolved mid-sweep still redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= '0;
      o_mispredict_cnt <= '0;
    end else begin
      o_redirect_valid <= fifo_push && mispredict;
      if (fifo_push && mispredict) begin
        o_redirect_pc    <= correct_pc;
        o_mispredict_cnt <= o_mispredict_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// Directed self-checking bench for bpu_update_ctrl.
module tb_bpu_update_ctrl;

  logic        clk;
  logic        rst;
  logic        i_ex_valid;
  logic        i_ex_is_branch;
  logic [31:0] i_ex_pc;
  logic        i_ex_taken;
  logic [31:0] i_ex_target;
  logic        i_ex_pred_taken;
  logic [31:0] i_ex_pred_target;
  logic        i_flush_req;
  logic        o_ex_stall;
  logic        o_upd_valid;
  logic [31:0] o_upd_pc;
  logic        o_upd_taken;
  logic [31:0] o_upd_target;
  logic        o_sweep_valid;
  logic [5:0]  o_sweep_index;
  logic        o_ready;
  logic        o_redirect_valid;
  logic [31:0] o_redirect_pc;
  logic [31:0] o_mispredict_cnt;

  int n_cmp;
  int n_fail;

  bpu_update_ctrl #(.ENTRIES(64), .IDX_W(6), .QDEPTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_ex_valid       (i_ex_valid),
    .i_ex_is_branch   (i_ex_is_branch),
    .i_ex_pc          (i_ex_pc),
    .i_ex_taken       (i_ex_taken),
    .i_ex_target      (i_ex_target),
    .i_ex_pred_taken  (i_ex_pred_taken),
    .i_ex_pred_target (i_ex_pred_target),
    .i_flush_req      (i_flush_req),
    .o_ex_stall       (o_ex_stall),
    .o_upd_valid      (o_upd_valid),
    .o_upd_pc         (o_upd_pc),
    .o_upd_taken      (o_upd_taken),
    .o_upd_target     (o_upd_target),
    .o_sweep_valid    (o_sweep_valid),
    .o_sweep_index    (o_sweep_index),
    .o_ready          (o_ready),
    .o_redirect_valid (o_redirect_valid),
    .o_redirect_pc    (o_redirect_pc),
    .o_mispredict_cnt (o_mispredict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                                input logic pred_taken, input logic [31:0] pred_target);
    i_ex_valid       = 1'b1;
    i_ex_is_branch   = 1'b1;
    i_ex_pc          = pc;
    i_ex_taken       = taken;
    i_ex_target      = target;
    i_ex_pred_taken  = pred_taken;
    i_ex_pred_target = pred_target;
  endtask

  task automatic clear_ex();
    i_ex_valid       = 1'b0;
    i_ex_is_branch   = 1'b0;
    i_ex_pc          = '0;
    i_ex_taken       = 1'b0;
    i_ex_target      = '0;
    i_ex_pred_taken  = 1'b0;
    i_ex_pred_target = '0;
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    rst         = 1'b1;
    i_flush_req = 1'b0;
    clear_ex();
    tick();
    tick();

    // Reset state
    check_output("rst_sweep_valid", 32'(o_sweep_valid), 32'd1);
    check_output("rst_sweep_index", 32'(o_sweep_index), 32'd0);
    check_output("rst_ready", 32'(o_ready), 32'd0);
    check_output("rst_upd_valid", 32'(o_upd_valid), 32'd0);
    check_output("rst_redirect_valid", 32'(o_redirect_valid), 32'd0);
    check_output("rst_redirect_pc", o_redirect_pc, 32'd0);
    check_output("rst_mp_cnt", o_mispredict_cnt, 32'd0);
    check_output("rst_stall", 32'(o_ex_stall), 32'd0);
    rst = 1'b0;

    // Initial sweep covers every index in order
    for (int k = 0; k < 64; k++) begin
      check_output("init_sweep_index", 32'(o_sweep_index), 32'(k));
      check_output("init_sweep_valid", 32'(o_sweep_valid), 32'd1);
      tick();
    end
    check_output("run_ready", 32'(o_ready), 32'd1);
    check_output("run_sweep_valid", 32'(o_sweep_valid), 32'd0);
    check_output("run_upd_idle", 32'(o_upd_valid), 32'd0);

    // Direction mispredict, actually taken
    apply_stimulus(32'h100, 1'b1, 32'h140, 1'b0, 32'h0);
    check_output("t1_stall", 32'(o_ex_stall), 32'd0);
    tick();
    clear_ex();
    check_output("t1_upd_valid", 32'(o_upd_valid), 32'd1);
    check_output("t1_upd_pc", o_upd_pc, 32'h100);
    check_output("t1_upd_taken", 32'(o_upd_taken), 32'd1);
    check_output("t1_upd_target", o_upd_target, 32'h140);
    check_output("t1_redir_valid", 32'(o_redirect_valid), 32'd1);
    check_output("t1_redir_pc", o_redirect_pc, 32'h140);
    check_output("t1_cnt", o_mispredict_cnt, 32'd1);
    tick();
    check_output("t1_upd_done", 32'(o_upd_valid), 32'd0);
    check_output("t1_redir_pulse", 32'(o_redirect_valid), 32'd0);

    // Direction mispredict, actually not taken
    apply_stimulus(32'h200, 1'b0, 32'h280, 1'b1, 32'h280);
    tick();
    clear_ex();
    check_output("t2_upd_pc", o_upd_pc, 32'h200);
    check_output("t2_upd_taken", 32'(o_upd_taken), 32'd0);
    check_output("t2_redir_valid", 32'(o_redirect_valid), 32'd1);
    check_output("t2_redir_pc", o_redirect_pc, 32'h204);
    check_output("t2_cnt", o_mispredict_cnt, 32'd2);
    tick();

    // Target mispredict
    apply_stimulus(32'h2F0, 1'b1, 32'h300, 1'b1, 32'h304);
    tick();
    clear_ex();
    check_output("t3_redir_valid", 32'(o_redirect_valid), 32'd1);
    check_output("t3_redir_pc", o_redirect_pc, 32'h300);
    check_output("t3_cnt", o_mispredict_cnt, 32'd3);
    tick();

    // Correct prediction still trains
    apply_stimulus(32'h400, 1'b1, 32'h480, 1'b1, 32'h480);
    tick();
    clear_ex();
    check_output("t4_upd_valid", 32'(o_upd_valid), 32'd1);
    check_output("t4_upd_pc", o_upd_pc, 32'h400);
    check_output("t4_redir_valid", 32'(o_redirect_valid), 32'd0);
    check_output("t4_cnt", o_mispredict_cnt, 32'd3);
    tick();

    // Non-branch is never queued or checked
    apply_stimulus(32'h500, 1'b1, 32'h600, 1'b0, 32'h0);
    i_ex_is_branch = 1'b0;
    tick();
    clear_ex();
    check_output("t5_upd_valid", 32'(o_upd_valid), 32'd0);
    check_output("t5_redir_valid", 32'(o_redirect_valid), 32'd0);
    check_output("t5_cnt", o_mispredict_cnt, 32'd3);
    tick();

    // pc+4 wraps at 2^32
    apply_stimulus(32'hFFFF_FFFC, 1'b0, 32'h10, 1'b1, 32'h10);
    tick();
    clear_ex();
    check_output("t6_redir_valid", 32'(o_redirect_valid), 32'd1);
    check_output("t6_redir_pc", o_redirect_pc, 32'h0);
    check_output("t6_cnt", o_mispredict_cnt, 32'd4);
    tick();

    // Fill the FIFO during INIT; the fifth branch must be held
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("t7_cnt_cleared", o_mispredict_cnt, 32'd0);
    check_output("t7_sweep_index", 32'(o_sweep_index), 32'd0);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(32'h1000 + 32'(16 * k), 1'b1, 32'h2000, 1'b1, 32'h2000);
      check_output("t7_stall_low", 32'(o_ex_stall), 32'd0);
      tick();
    end
    apply_stimulus(32'h1040, 1'b1, 32'h2000, 1'b1, 32'h2000);
    check_output("t7_stall_full", 32'(o_ex_stall), 32'd1);
    for (int n = 0; n < 100 && !o_ready; n++) begin
      tick();
    end
    check_output("t7_ready_timeout", 32'(o_ready), 32'd1);
    check_output("t7_c0_valid", 32'(o_upd_valid), 32'd1);
    check_output("t7_c0_pc", o_upd_pc, 32'h1000);
    check_output("t7_c0_stall", 32'(o_ex_stall), 32'd1);
    tick();
    check_output("t7_c1_pc", o_upd_pc, 32'h1010);
    check_output("t7_c1_stall", 32'(o_ex_stall), 32'd0);
    tick();
    clear_ex();
    check_output("t7_c2_pc", o_upd_pc, 32'h1020);
    tick();
    check_output("t7_c3_pc", o_upd_pc, 32'h1030);
    tick();
    check_output("t7_c4_valid", 32'(o_upd_valid), 32'd1);
    check_output("t7_c4_pc", o_upd_pc, 32'h1040);
    check_output("t7_c4_target", o_upd_target, 32'h2000);
    tick();
    check_output("t7_c5_valid", 32'(o_upd_valid), 32'd0);
    check_output("t7_redir_none", o_mispredict_cnt, 32'd0);

    // Flush with a push in the same cycle; a mid-sweep push survives
    apply_stimulus(32'h3000, 1'b0, 32'h3100, 1'b0, 32'h3100);
    tick();
    check_output("t8_a_upd", o_upd_pc, 32'h3000);
    apply_stimulus(32'h3010, 1'b1, 32'h3100, 1'b1, 32'h3100);
    i_flush_req = 1'b1;
    tick();
    clear_ex();
    i_flush_req = 1'b0;
    for (int k = 0; k < 64; k++) begin
      check_output("t8_sweep_index", 32'(o_sweep_index), 32'(k));
      check_output("t8_sweep_valid", 32'(o_sweep_valid), 32'd1);
      check_output("t8_no_upd", 32'(o_upd_valid), 32'd0);
      if (k == 10) apply_stimulus(32'h5000, 1'b1, 32'h5040, 1'b0, 32'h0);
      if (k == 11) begin
        clear_ex();
        check_output("t8_redir_valid", 32'(o_redirect_valid), 32'd1);
        check_output("t8_redir_pc", o_redirect_pc, 32'h5040);
      end
      if (k == 20) i_flush_req = 1'b1;
      if (k == 21) i_flush_req = 1'b0;
      tick();
    end
    check_output("t8_ready", 32'(o_ready), 32'd1);
    check_output("t8_upd_valid", 32'(o_upd_valid), 32'd1);
    check_output("t8_upd_pc", o_upd_pc, 32'h5000);
    check_output("t8_upd_target", o_upd_target, 32'h5040);
    check_output("t8_cnt", o_mispredict_cnt, 32'd1);
    tick();
    check_output("t8_flushed_push", 32'(o_upd_valid), 32'd0);

    // Reset in the middle of a flush sweep
    i_flush_req = 1'b1;
    tick();
    i_flush_req = 1'b0;
    for (int k = 0; k < 29; k++) begin
      tick();
    end
    check_output("t9_index29", 32'(o_sweep_index), 32'd29);
    apply_stimulus(32'h6000, 1'b0, 32'h6100, 1'b1, 32'h6100);
    tick();
    check_output("t9_index30", 32'(o_sweep_index), 32'd30);
    check_output("t9_redir_pre", 32'(o_redirect_valid), 32'd1);
    check_output("t9_redir_pc_pre", o_redirect_pc, 32'h6004);
    check_output("t9_cnt_pre", o_mispredict_cnt, 32'd2);
    apply_stimulus(32'h7000, 1'b1, 32'h7100, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_ex();
    check_output("t9_sweep_valid", 32'(o_sweep_valid), 32'd1);
    check_output("t9_sweep_index", 32'(o_sweep_index), 32'd0);
    check_output("t9_ready", 32'(o_ready), 32'd0);
    check_output("t9_cnt", o_mispredict_cnt, 32'd0);
    check_output("t9_redir_valid", 32'(o_redirect_valid), 32'd0);
    check_output("t9_redir_pc", o_redirect_pc, 32'd0);
    check_output("t9_stall", 32'(o_ex_stall), 32'd0);
    for (int n = 0; n < 100 && !o_ready; n++) begin
      tick();
    end
    check_output("t9_ready_timeout", 32'(o_ready), 32'd1);
    check_output("t9_fifo_empty", 32'(o_upd_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
